fixed_multiply: RTL and testbench

Iterative unsigned fixed-point multiplier that is the inverse of `fixed_divide`. It takes a 26-bit Q1.25 quotient, which is the format `fixed_divide` emits, and a 24-bit integer divisor, and produces the 24-bit integer product `floor(quotient * divisor / 2^25)`, saturated on overflow. It sits downstream of the divide stage wherever a normalized ratio must be rescaled back to the integer domain, for example re-projecting normalized coordinates. It uses one shift-add step per cycle with valid/ready handshakes on both sides.

---
 rtl/fixed_multiply_if.sv | 34 +++
 rtl/fixed_multiply.sv | 82 ++++++++
 tb/tb_fixed_multiply.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fixed_multiply_if.sv
// Operand/result handshake bundle for the Q1.25 x integer shift-add multiplier.
// Signal names are from the multiplier's point of view.
interface fixed_multiply_if;
  logic        valid_in;
  logic [25:0] quotient_in;
  logic [23:0] divisor_in;
  logic        ready_out;
  logic        valid_out;
  logic        ready_in;
  logic [23:0] product_out;
  logic        overflow_out;

  modport master (
    output valid_in,
    output quotient_in,
    output divisor_in,
    input  ready_out,
    input  valid_out,
    output ready_in,
    input  product_out,
    input  overflow_out
  );

  modport slave (
    input  valid_in,
    input  quotient_in,
    input  divisor_in,
    output ready_out,
    output valid_out,
    input  ready_in,
    output product_out,
    output overflow_out
  );
endinterface

// File: rtl/fixed_multiply.sv
// Iterative unsigned multiplier: floor(q * d / 2^25) for Q1.25 q and 24-bit d,
// one quotient bit per cycle LSB first, saturating to 24'hFFFFFF.
module fixed_multiply (
  input  logic             clk_in,
  input  logic             rst_in,
  fixed_multiply_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [4:0] LastBit = 5'd25;

  state_e      state_q;
  logic [25:0] q_q;
  logic [23:0] d_q;
  logic [49:0] acc_q;
  logic [4:0]  cnt_q;

  logic [49:0] addend;
  logic [49:0] acc_sum;

  // Partial product for the current quotient bit; full 50-bit width, no truncation.
  always_comb begin
    addend = '0;
    if (q_q[0]) begin
      addend = {26'd0, d_q} << cnt_q;
    end
    acc_sum = acc_q + addend;
  end

  assign bus.ready_out = (state_q == StIdle);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= StIdle;
      q_q              <= '0;
      d_q              <= '0;
      acc_q            <= '0;
      cnt_q            <= '0;
      bus.valid_out    <= 1'b0;
      bus.product_out  <= '0;
      bus.overflow_out <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.valid_in) begin
            q_q     <= bus.quotient_in;
            d_q     <= bus.divisor_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          acc_q <= acc_sum;
          q_q   <= q_q >> 1;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == LastBit) begin
            state_q       <= StDone;
            bus.valid_out <= 1'b1;
            // Bit 49 set means the scaled result no longer fits in 24 bits.
            if (acc_sum[49]) begin
              bus.product_out  <= 24'hFFFFFF;
              bus.overflow_out <= 1'b1;
            end else begin
              bus.product_out  <= acc_sum[48:25];
              bus.overflow_out <= 1'b0;
            end
          end
        end
        StDone: begin
          if (bus.ready_in) begin
            state_q       <= StIdle;
            bus.valid_out <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_multiply.sv
// Directed bench for fixed_multiply: arithmetic model plus literal expectations,
// latency, backpressure and asynchronous reset behaviour.
module tb_fixed_multiply;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fixed_multiply_if bus ();

  fixed_multiply u_dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [24:0] exp_mdl = '0;  // {overflow, product} of the operation in flight

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Exact-arithmetic reference: full product, then scale or saturate.
  function automatic logic [24:0] model(input logic [25:0] q, input logic [23:0] d);
    longint unsigned full;
    full = longint'(q) * longint'(d);
    if (full >= (64'd1 << 49)) return {1'b1, 24'hFFFFFF};
    return {1'b0, 24'(full >> 25)};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.valid_out) begin
      check("cmp_product", 64'(bus.product_out), 64'(exp_mdl[23:0]));
      check("cmp_overflow", 64'(bus.overflow_out), 64'(exp_mdl[24]));
    end
  end

  task automatic start_op(input logic [25:0] q, input logic [23:0] d);
    @(negedge clk);
    check("ready_before_accept", 64'(bus.ready_out), 64'd1);
    bus.valid_in    = 1'b1;
    bus.quotient_in = q;
    bus.divisor_in  = d;
    exp_mdl         = model(q, d);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic finish_op(input string name, input logic [23:0] exp_p, input logic exp_o,
                           input int hold);
    int n;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.valid_out) break;
    end
    check({name, "_latency"}, 64'(n), 64'd26);
    check({name, "_product"}, 64'(bus.product_out), 64'(exp_p));
    check({name, "_overflow"}, 64'(bus.overflow_out), 64'(exp_o));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_ready"}, 64'(bus.ready_out), 64'd0);
      check({name, "_hold_valid"}, 64'(bus.valid_out), 64'd1);
      check({name, "_hold_product"}, 64'(bus.product_out), 64'(exp_p));
      bus.valid_in    = i[0];
      bus.quotient_in = 26'($urandom);
      bus.divisor_in  = 24'($urandom);
    end
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    check({name, "_hs_valid"}, 64'(bus.valid_out), 64'd0);
    check({name, "_hs_ready"}, 64'(bus.ready_out), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [25:0] q, input logic [23:0] d,
                        input logic [23:0] exp_p, input logic exp_o, input int hold);
    start_op(q, d);
    finish_op(name, exp_p, exp_o, hold);
  endtask

  initial begin
    bus.valid_in    = 1'b0;
    bus.quotient_in = '0;
    bus.divisor_in  = '0;
    bus.ready_in    = 1'b0;

    // Literal pins on the model itself.
    check("mdl_unity", 64'(model(26'h2000000, 24'd1000)), 64'd1000);
    check("mdl_trunc", 64'(model(26'h1000000, 24'd7)), 64'd3);
    check("mdl_sat", 64'(model(26'h3FFFFFF, 24'hFFFFFF)), 64'h1FFFFFF);
    check("mdl_roundtrip", 64'(model(26'd22469485, 24'd448)), 64'd299);

    #2;
    check("rst_ready", 64'(bus.ready_out), 64'd1);
    check("rst_valid", 64'(bus.valid_out), 64'd0);
    check("rst_product", 64'(bus.product_out), 64'd0);
    check("rst_overflow", 64'(bus.overflow_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op("unity", 26'h2000000, 24'd1000, 24'd1000, 1'b0, 3);
    run_op("trunc", 26'h1000000, 24'd7, 24'd3, 1'b0, 0);
    run_op("max_exact", 26'h2000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 0);
    run_op("saturate", 26'h3FFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 0);
    // floor(300*2^25/448) = 22469485; rescaling loses one LSB.
    run_op("rt_floor", 26'd22469485, 24'd448, 24'd299, 1'b0, 0);
    // 448/1792 = 0.25 exactly, so the round trip is exact.
    run_op("rt_exact", 26'h0800000, 24'd1792, 24'd448, 1'b0, 0);
    run_op("zero_q", 26'h0, 24'd12345, 24'd0, 1'b0, 0);
    run_op("zero_d", 26'h3ABCDEF, 24'd0, 24'd0, 1'b0, 0);
    run_op("backpressure", 26'h2000000, 24'd55, 24'd55, 1'b0, 10);
    run_op("after_bp", 26'h1800000, 24'd40, 24'd30, 1'b0, 0);

    // Abort mid-operation with an asynchronous reset between edges.
    start_op(26'h3FFFFFF, 24'hFFFFFF);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 64'(bus.ready_out), 64'd1);
    check("arst_valid", 64'(bus.valid_out), 64'd0);
    check("arst_product", 64'(bus.product_out), 64'd0);
    check("arst_overflow", 64'(bus.overflow_out), 64'd0);
    @(negedge clk);
    bus.valid_in    = 1'b1;
    bus.quotient_in = 26'h3FFFFFF;
    bus.divisor_in  = 24'hFFFFFF;
    @(posedge clk);
    #1;
    check("arst_no_accept", 64'(bus.ready_out), 64'd1);
    @(negedge clk);
    bus.valid_in = 1'b0;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("arst_no_result", 64'(bus.valid_out), 64'd0);
    run_op("post_reset", 26'h0800000, 24'd400, 24'd100, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
